led_scan_pwm: RTL

//  Parametrised successor to the board's fixed user-LED drive: time-multiplexes NUM_LEDS

---
 rtl/led_scan_pwm_if.sv | 16 +
 rtl/led_scan_pwm.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_scan_pwm_if.sv
// Register-bus write port of the LED scan/PWM block: duty writes in,
// out-of-range index error pulse back.
interface led_scan_pwm_if #(
    parameter int NUM_LEDS = 7,
    parameter int PWM_BITS = 8
);
    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [3*PWM_BITS-1:0] wr_rgb;
    logic                  wr_err;

    modport master (output wr_en, output wr_idx, output wr_rgb, input wr_err);
    modport slave  (input wr_en, input wr_idx, input wr_rgb, output wr_err);
endinterface

// File: rtl/led_scan_pwm.sv
// Time-multiplexed RGB LED driver. Each LED gets one slot per frame: a few
// all-off blanking ticks, then a PWM drive phase of 2^PWM_BITS-1 ticks.
// Duty values are double-buffered (shadow written by the bus, active used
// by the scan) and the shadow is copied into active only at frame start.
module led_scan_pwm #(
    parameter int NUM_LEDS    = 7,
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 4,
    parameter int BLANK_TICKS = 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                enable,
    led_scan_pwm_if.slave       wr_bus,
    output logic                frame_start,
    output logic [NUM_LEDS-1:0] leds_en,
    output logic [2:0]          leds_color
);

    localparam int IDX_W = (NUM_LEDS > 1)    ? $clog2(NUM_LEDS)    : 1;
    localparam int PRE_W = (PRESCALE > 1)    ? $clog2(PRESCALE)    : 1;
    localparam int BLK_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam int RGB_W = 3 * PWM_BITS;

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0]    BLK_LAST  = BLK_W'(BLANK_TICKS - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [IDX_W-1:0]    SLOT_LAST = IDX_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [BLK_W-1:0]      blk_q, blk_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [IDX_W-1:0]      slot_q, slot_d;
    logic                  fs_d;
    logic [NUM_LEDS-1:0]   en_d;
    logic [2:0]            col_d;
    logic                  tick;
    logic                  commit;
    logic                  wr_valid;

    logic [RGB_W-1:0]      shadow_q [NUM_LEDS];
    logic [RGB_W-1:0]      active_q [NUM_LEDS];

    // Colour lines for one LED at a given PWM count: on while count < duty.
    function automatic logic [2:0] pwm_color(input logic [RGB_W-1:0]    duty,
                                             input logic [PWM_BITS-1:0] cnt);
        return {cnt < duty[RGB_W-1 -: PWM_BITS],
                cnt < duty[2*PWM_BITS-1 -: PWM_BITS],
                cnt < duty[PWM_BITS-1:0]};
    endfunction

    // Widened compare so NUM_LEDS equal to a power of two still works.
    assign wr_valid = ({1'b0, wr_bus.wr_idx} < (IDX_W + 1)'(NUM_LEDS));

    // Scan FSM state, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            blk_q       <= '0;
            pwm_q       <= '0;
            slot_q      <= '0;
            frame_start <= 1'b0;
            leds_en     <= '0;
            leds_color  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            state_q     <= state_d;
            pre_q       <= pre_d;
            blk_q       <= blk_d;
            pwm_q       <= pwm_d;
            slot_q      <= slot_d;
            frame_start <= fs_d;
            leds_en     <= en_d;
            leds_color  <= col_d;
        end
    end

    // Next-state, counter and output decode for the scan FSM.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        pre_d   = pre_q;
        blk_d   = blk_q;
        pwm_d   = pwm_q;
        slot_d  = slot_q;
        fs_d    = 1'b0;
        en_d    = leds_en;
        col_d   = leds_color;
        commit  = 1'b0;
        tick    = (pre_q == PRE_LAST);

        if (!enable) begin
            state_d = IDLE;
            pre_d   = '0;
            blk_d   = '0;
            pwm_d   = '0;
            slot_d  = '0;
            en_d    = '0;
            col_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    pre_d   = '0;
                    blk_d   = '0;
                    pwm_d   = '0;
                    slot_d  = '0;
                    commit  = 1'b1;
                    fs_d    = 1'b1;
                    en_d    = '0;
                    col_d   = '0;
                end
                BLANK: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    en_d  = '0;
                    col_d = '0;
                    if (tick) begin
                        if (blk_q == BLK_LAST) begin
                            state_d = DRIVE;
                            blk_d   = '0;
                            pwm_d   = '0;
                            en_d    = NUM_LEDS'(1) << slot_q;
                            col_d   = pwm_color(active_q[slot_q], '0);
                        end else begin
                            blk_d = blk_q + 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        if (pwm_q == PWM_LAST) begin
                            state_d = BLANK;
                            pwm_d   = '0;
                            en_d    = '0;
                            col_d   = '0;
                            if (slot_q == SLOT_LAST) begin
                                slot_d = '0;
                                commit = 1'b1;
                                fs_d   = 1'b1;
                            end else begin
                                slot_d = slot_q + 1'b1;
                            end
                        end else begin
                            pwm_d = pwm_q + 1'b1;
                            col_d = pwm_color(active_q[slot_q], pwm_q + 1'b1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    en_d    = '0;
                    col_d   = '0;
                end
            endcase
        end
    end

    // Bus writes into the shadow buffer; out-of-range index raises wr_err.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: the duty buffers are reset explicitly because a freshly
            // reset board must show all LEDs dark, not whatever the RAM held.
            for (int i = 0; i < NUM_LEDS; i++) begin
                shadow_q[i] <= '0;
            end
            wr_bus.wr_err <= 1'b0;
        end else begin
            wr_bus.wr_err <= wr_bus.wr_en && !wr_valid;
            if (wr_bus.wr_en && wr_valid) begin
                shadow_q[wr_bus.wr_idx] <= wr_bus.wr_rgb;
            end
        end
    end

    // Frame commit: the scan only ever sees a consistent copy of the shadow.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                active_q[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

endmodule
